// File: rtl/dmem_mmio_responder.sv
// Data-memory responder: on-chip RAM at the bottom of the word address space,
// plus GPIO, timer/compare and a TX FIFO mapped at 0xF00..0xF04.
module dmem_mmio_responder #(
    parameter int RAM_WORDS = 256,
    parameter int TX_DEPTH  = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [11:0] address,
    input  logic [31:0] data,
    input  logic        wren,
    output logic [31:0] q,
    output logic [31:0] gpio_out,
    output logic [31:0] tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        irq
);

    localparam int AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
    localparam int PW = $clog2(TX_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [11:0] RAM_LIMIT    = 12'(RAM_WORDS);
    localparam logic [11:0] ADDR_GPIO    = 12'hF00;
    localparam logic [11:0] ADDR_TIMER   = 12'hF01;
    localparam logic [11:0] ADDR_COMPARE = 12'hF02;
    localparam logic [11:0] ADDR_STATUS  = 12'hF03;
    localparam logic [11:0] ADDR_TXDATA  = 12'hF04;

    logic [31:0]   r_ram [RAM_WORDS];
    logic [31:0]   r_ram_rd;
    logic          r_rd_is_ram;
    logic [31:0]   r_reg_rd;

    logic [31:0]   r_gpio;
    logic [31:0]   r_timer;
    logic [31:0]   r_compare;
    logic          r_match;
    logic          r_ovf;

    logic [31:0]   r_fifo [TX_DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic          w_in_ram;
    logic [AW-1:0] w_ram_idx;
    logic          w_wr_gpio;
    logic          w_wr_timer;
    logic          w_wr_compare;
    logic          w_wr_status;
    logic          w_push;
    logic          w_pop;
    logic          w_push_ok;
    logic          w_drop;
    logic          w_full;
    logic          w_empty;
    logic          w_timer_hit;
    logic [3:0]    w_count4;
    logic [31:0]   w_status;
    logic [31:0]   w_reg_rd;

    assign w_in_ram     = (address < RAM_LIMIT);
    assign w_ram_idx    = address[AW-1:0];
    assign w_wr_gpio    = wren && (address == ADDR_GPIO);
    assign w_wr_timer   = wren && (address == ADDR_TIMER);
    assign w_wr_compare = wren && (address == ADDR_COMPARE);
    assign w_wr_status  = wren && (address == ADDR_STATUS);
    assign w_push       = wren && (address == ADDR_TXDATA);

    assign w_full      = (r_count == CW'(TX_DEPTH));
    assign w_empty     = (r_count == '0);
    assign w_pop       = !w_empty && tx_ready;
    // A pop frees a slot in the same edge, so a full FIFO can still take a push.
    assign w_push_ok   = w_push && (!w_full || w_pop);
    assign w_drop      = w_push && !w_push_ok;
    assign w_timer_hit = (r_timer == r_compare);

    assign w_count4 = 4'(r_count);
    assign w_status = {24'h0, w_count4, w_empty, r_ovf, w_full, r_match};

    always_comb begin
        w_reg_rd = 32'h0;
        case (address)
            ADDR_GPIO:    w_reg_rd = r_gpio;
            ADDR_TIMER:   w_reg_rd = r_timer;
            ADDR_COMPARE: w_reg_rd = r_compare;
            ADDR_STATUS:  w_reg_rd = w_status;
            default:      w_reg_rd = 32'h0;
        endcase
    end

    // RAM and FIFO storage carry no reset so they map onto memory primitives.
    always_ff @(posedge clock) begin
        if (!reset && wren && w_in_ram)
            r_ram[w_ram_idx] <= data;
        r_ram_rd <= r_ram[w_ram_idx];
    end

    always_ff @(posedge clock) begin
        if (!reset && w_push_ok)
            r_fifo[r_wr_ptr] <= data;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rd_is_ram <= 1'b0;
            r_reg_rd    <= 32'h0;
            r_gpio      <= 32'h0;
            r_timer     <= 32'h0;
            r_compare   <= 32'hFFFF_FFFF;
            r_match     <= 1'b0;
            r_ovf       <= 1'b0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
        end else begin
            r_rd_is_ram <= w_in_ram;
            r_reg_rd    <= w_reg_rd;

            if (w_wr_gpio)
                r_gpio <= data;
            if (w_wr_compare)
                r_compare <= data;
            r_timer <= w_wr_timer ? data : (r_timer + 32'd1);

            // Sticky flags: a new event in the same cycle beats a W1C.
            if (w_timer_hit)
                r_match <= 1'b1;
            else if (w_wr_status && data[0])
                r_match <= 1'b0;
            if (w_drop)
                r_ovf <= 1'b1;
            else if (w_wr_status && data[2])
                r_ovf <= 1'b0;

            if (w_push_ok)
                r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign q        = r_rd_is_ram ? r_ram_rd : r_reg_rd;
    assign gpio_out = r_gpio;
    assign tx_valid = !w_empty;
    assign tx_data  = tx_valid ? r_fifo[r_rd_ptr] : 32'h0;
    assign irq      = r_match;

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Directed bench for dmem_mmio_responder: table of single-cycle accesses plus
// hand-written timer, FIFO and reset sequences.
module tb_dmem_mmio_responder;

    logic        clock;
    logic        reset;
    logic [11:0] address;
    logic [31:0] data;
    logic        wren;
    logic [31:0] q;
    logic [31:0] gpio_out;
    logic [31:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        irq;

    int checks;
    int errors;

    typedef struct {
        logic [11:0] addr;
        logic [31:0] wdata;
        logic        we;
        logic        chk;
        logic [31:0] exp_q;
    } vec_t;

    vec_t vecs [21];

    dmem_mmio_responder #(.RAM_WORDS(256), .TX_DEPTH(4)) dut (
        .clock    (clock),
        .reset    (reset),
        .address  (address),
        .data     (data),
        .wren     (wren),
        .q        (q),
        .gpio_out (gpio_out),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .irq      (irq)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic cycle(input logic [11:0] a, input logic [31:0] d, input logic w);
        address = a;
        data    = d;
        wren    = w;
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        cycle(12'h800, 32'h0, 1'b0);
    endtask

    initial begin
        logic [31:0] drain_exp [4];
        int          rise_at;

        checks   = 0;
        errors   = 0;
        reset    = 1'b1;
        address  = 12'h0;
        data     = 32'h0;
        wren     = 1'b0;
        tx_ready = 1'b0;

        vecs[0]  = '{12'h005, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0};
        vecs[1]  = '{12'h005, 32'h0,        1'b0, 1'b1, 32'hDEADBEEF};
        vecs[2]  = '{12'h005, 32'h11111111, 1'b1, 1'b1, 32'hDEADBEEF};
        vecs[3]  = '{12'h005, 32'h0,        1'b0, 1'b1, 32'h11111111};
        vecs[4]  = '{12'h200, 32'h0,        1'b0, 1'b1, 32'h0};
        vecs[5]  = '{12'h000, 32'h00000001, 1'b1, 1'b0, 32'h0};
        vecs[6]  = '{12'h0FF, 32'h00000002, 1'b1, 1'b0, 32'h0};
        vecs[7]  = '{12'h000, 32'h0,        1'b0, 1'b1, 32'h00000001};
        vecs[8]  = '{12'h0FF, 32'h0,        1'b0, 1'b1, 32'h00000002};
        vecs[9]  = '{12'h100, 32'h55555555, 1'b1, 1'b1, 32'h0};
        vecs[10] = '{12'h100, 32'h0,        1'b0, 1'b1, 32'h0};
        vecs[11] = '{12'hF00, 32'h12345678, 1'b1, 1'b1, 32'h0};
        vecs[12] = '{12'hF00, 32'h0,        1'b0, 1'b1, 32'h12345678};
        vecs[13] = '{12'hF02, 32'hAABBCCDD, 1'b1, 1'b1, 32'hFFFFFFFF};
        vecs[14] = '{12'hF02, 32'h0,        1'b0, 1'b1, 32'hAABBCCDD};
        vecs[15] = '{12'hF03, 32'hFFFFFFFF, 1'b1, 1'b1, 32'h00000008};
        vecs[16] = '{12'hF03, 32'h0,        1'b0, 1'b1, 32'h00000008};
        vecs[17] = '{12'hF04, 32'h0,        1'b0, 1'b1, 32'h0};
        vecs[18] = '{12'hF05, 32'h0,        1'b0, 1'b1, 32'h0};
        vecs[19] = '{12'hFFF, 32'h0,        1'b0, 1'b1, 32'h0};
        vecs[20] = '{12'h000, 32'h0,        1'b0, 1'b1, 32'h00000001};

        // Reset state
        idle();
        idle();
        reset = 1'b0;
        chk("reset_q", q, 32'h0);
        chk("reset_gpio", gpio_out, 32'h0);
        chk("reset_tx_valid", {31'h0, tx_valid}, 32'h0);
        chk("reset_tx_data", tx_data, 32'h0);
        chk("reset_irq", {31'h0, irq}, 32'h0);
        cycle(12'hF03, 32'h0, 1'b0);
        chk("reset_status", q, 32'h00000008);
        $display("reset: status q=0x%08h", q);

        // Table-driven single-cycle accesses
        for (int i = 0; i < 21; i++) begin
            cycle(vecs[i].addr, vecs[i].wdata, vecs[i].we);
            $display("vec %0d: addr=0x%03h we=%0d wdata=0x%08h q=0x%08h",
                     i, vecs[i].addr, vecs[i].we, vecs[i].wdata, q);
            if (vecs[i].chk)
                chk($sformatf("vec%0d_q", i), q, vecs[i].exp_q);
        end
        chk("gpio_out", gpio_out, 32'h12345678);

        // Timer compare: match on pre-count 10, irq visible right after that edge
        cycle(12'hF02, 32'd10, 1'b1);
        cycle(12'hF01, 32'd0, 1'b1);
        chk("irq_before_match", {31'h0, irq}, 32'h0);
        rise_at = -1;
        for (int n = 1; n <= 14; n++) begin
            idle();
            if (irq && rise_at < 0)
                rise_at = n;
        end
        chk("irq_rise_cycle", 32'(rise_at), 32'd14 - 32'd3);
        $display("timer: irq rose %0d cycles after TIMER=0 write", rise_at);
        cycle(12'hF02, 32'hFFFFFFF0, 1'b1);
        cycle(12'hF03, 32'h1, 1'b1);
        chk("irq_w1c", {31'h0, irq}, 32'h0);
        cycle(12'hF03, 32'h0, 1'b0);
        chk("status_after_w1c", q, 32'h00000008);

        // W1C in the same edge as a fresh match: set wins
        cycle(12'hF01, 32'hFFFFFFEF, 1'b1);
        idle();
        cycle(12'hF03, 32'h1, 1'b1);
        chk("match_set_wins", {31'h0, irq}, 32'h1);
        cycle(12'hF03, 32'h1, 1'b1);
        chk("match_clear", {31'h0, irq}, 32'h0);

        // Timer wrap: pre-count FFFFFFFF, then 0
        cycle(12'hF01, 32'hFFFFFFFF, 1'b1);
        cycle(12'hF01, 32'h0, 1'b0);
        chk("timer_max", q, 32'hFFFFFFFF);
        cycle(12'hF01, 32'h0, 1'b0);
        chk("timer_wrap", q, 32'h00000000);
        $display("timer: wrap read q=0x%08h", q);

        // FIFO: fill with overflow while the consumer stalls
        tx_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            cycle(12'hF04, 32'(i), 1'b1);
            chk($sformatf("push%0d_q", i), q, 32'h0);
            if (i == 1) begin
                chk("tx_valid_after_push", {31'h0, tx_valid}, 32'h1);
                chk("tx_data_after_push", tx_data, 32'h1);
            end
            $display("push %0d: tx_valid=%0d tx_data=0x%08h", i, tx_valid, tx_data);
        end
        cycle(12'hF03, 32'h0, 1'b0);
        chk("status_full_ovf", q, 32'h00000046);
        chk("tx_data_held", tx_data, 32'h1);
        cycle(12'hF03, 32'h4, 1'b1);
        chk("status_w1c_read_old", q, 32'h00000046);
        cycle(12'hF03, 32'h0, 1'b0);
        chk("status_ovf_cleared", q, 32'h00000042);

        // Push and pop together while full
        tx_ready = 1'b1;
        cycle(12'hF04, 32'h6, 1'b1);
        tx_ready = 1'b0;
        chk("pushpop_head", tx_data, 32'h2);
        cycle(12'hF03, 32'h0, 1'b0);
        chk("pushpop_status", q, 32'h00000042);

        drain_exp[0] = 32'h2;
        drain_exp[1] = 32'h3;
        drain_exp[2] = 32'h4;
        drain_exp[3] = 32'h6;
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drain%0d_valid", i), {31'h0, tx_valid}, 32'h1);
            chk($sformatf("drain%0d_data", i), tx_data, drain_exp[i]);
            $display("pop %0d: tx_data=0x%08h", i, tx_data);
            idle();
        end
        chk("drained_valid", {31'h0, tx_valid}, 32'h0);
        tx_ready = 1'b0;
        cycle(12'hF03, 32'h0, 1'b0);
        chk("drained_status", q, 32'h00000008);

        // Reset mid-activity: FIFO and timer cleared, RAM retained
        cycle(12'h007, 32'hCAFEF00D, 1'b1);
        cycle(12'hF04, 32'hA1, 1'b1);
        cycle(12'hF04, 32'hA2, 1'b1);
        cycle(12'hF04, 32'hA3, 1'b1);
        cycle(12'hF03, 32'h0, 1'b0);
        chk("pre_reset_status", q, 32'h00000030);
        cycle(12'hF00, 32'hFFFF0000, 1'b1);
        reset    = 1'b1;
        tx_ready = 1'b1;
        idle();
        reset    = 1'b0;
        tx_ready = 1'b0;
        chk("mid_reset_tx_valid", {31'h0, tx_valid}, 32'h0);
        chk("mid_reset_gpio", gpio_out, 32'h0);
        chk("mid_reset_q", q, 32'h0);
        cycle(12'hF01, 32'h0, 1'b0);
        chk("mid_reset_timer", q, 32'h0);
        cycle(12'h007, 32'h0, 1'b0);
        chk("ram_retained", q, 32'hCAFEF00D);
        cycle(12'hF03, 32'h0, 1'b0);
        chk("mid_reset_status", q, 32'h00000008);
        $display("reset: tx_valid=%0d ram[7]=0x%08h", tx_valid, 32'hCAFEF00D);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
